// File: rtl/writeback_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | writeback_regfile: W-stage result select, 32x32 GPR file, bypassed   |
// | read ports and committed-write counter.          Revision: 1.0       |
// +----------------------------------------------------------------------+
module writeback_regfile #(
  parameter logic [31:0] SP_RESET = 32'h0000_0000,
  parameter logic [31:0] GP_RESET = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RegWriteW,
  input  logic        MemtoRegW,
  input  logic        JumpLinkW,
  input  logic [31:0] ALUOutW,
  input  logic [31:0] ReadDataW,
  input  logic [4:0]  WriteRegW,
  input  logic [31:0] PCPlus4W,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic [31:0] ResultW,
  output logic [31:0] WbCount
);

  logic [31:0] r_regs [32];
  logic [31:0] r_wbcount;
  logic        w_we_eff;
  logic [4:0]  w_wa_eff;

  assign ResultW  = JumpLinkW ? PCPlus4W : (MemtoRegW ? ReadDataW : ALUOutW);
  assign w_we_eff = (RegWriteW | JumpLinkW) & ~RST;
  assign w_wa_eff = JumpLinkW ? 5'd31 : WriteRegW;
  assign WbCount  = r_wbcount;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) begin
        if (i == 28)      r_regs[i] <= GP_RESET;
        else if (i == 29) r_regs[i] <= SP_RESET;
        else              r_regs[i] <= 32'h0;
      end
      r_wbcount <= 32'h0;
    end else if (w_we_eff && (w_wa_eff != 5'd0)) begin
      r_regs[w_wa_eff] <= ResultW;
      r_wbcount        <= r_wbcount + 32'd1;
    end
  end

  // Write-first: a matching in-flight write is visible in the same cycle.
  always_comb begin
    RD1 = 32'h0;
    if (A1 != 5'd0) begin
      if (w_we_eff && (w_wa_eff == A1)) RD1 = ResultW;
      else                              RD1 = r_regs[A1];
    end
  end

  always_comb begin
    RD2 = 32'h0;
    if (A2 != 5'd0) begin
      if (w_we_eff && (w_wa_eff == A2)) RD2 = ResultW;
      else                              RD2 = r_regs[A2];
    end
  end

endmodule
`default_nettype wire
